// File: rtl/pc_branch_pkg.sv
// pc_branch_pkg: shared encodings for the branch sequencer.
//   op_e        - branch operation codes carried on the op port
//   state_e     - sequencer FSM state encoding
//   TAKEN_CNT_W - width of the optional taken-branch counter
package pc_branch_pkg;

    typedef enum logic [1:0] {
        OP_NOP = 2'd0,
        OP_JMP = 2'd1,
        OP_JZ  = 2'd2,
        OP_JNZ = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_COMMIT = 2'd2
    } state_e;

    localparam int TAKEN_CNT_W = 8;

endpackage

// File: rtl/pc_branch_decide.sv
// pc_branch_decide: combinational branch decision.
//   op   (in)  held branch operation
//   z    (in)  comparator zero flag (1 = AC equals bus)
//   take (out) 1 when the pc must load the branch target
module pc_branch_decide
    import pc_branch_pkg::*;
(
    input  op_e  op,
    input  logic z,
    output logic take
);

    always_comb begin
        take = 1'b0;
        case (op)
            OP_JMP:  take = 1'b1;
            OP_JZ:   take = z;
            OP_JNZ:  take = ~z;
            default: take = 1'b0;
        endcase
    end

endmodule

// File: rtl/pc_branch_seq.sv
// pc_branch_seq: program-counter branch sequencer.
// Accepts one branch op in IDLE, waits one SETTLE cycle so the comparator
// output is stable after an AC load on the accept edge, then commits in
// COMMIT (held there while stall is high). pc either loads the captured
// target or increments (wrapping).
//
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   op_valid/op_ready  op handshake (ready only in IDLE)
//   op, target         branch operation and destination, captured on accept
//   z                  comparator zero flag, sampled on the commit edge
//   stall              holds the COMMIT state
//   pc                 registered program counter
//   taken              one-cycle pulse after a commit that loaded target
//   busy               state is not IDLE
//   taken_cnt          saturating taken-branch count (PC_BRANCH_STATS_EN only)
//
// Build option: define PC_BRANCH_STATS_EN to add the taken_cnt output.
module pc_branch_seq
    import pc_branch_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             op_valid,
    output logic             op_ready,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] target,
    input  logic             z,
    input  logic             stall,
    output logic [WIDTH-1:0] pc,
    output logic             taken,
    output logic             busy
`ifdef PC_BRANCH_STATS_EN
    ,
    output logic [TAKEN_CNT_W-1:0] taken_cnt
`endif
);

    state_e           state, state_nxt;
    op_e              op_q;
    logic [WIDTH-1:0] target_q;
    logic             ready_en;
    logic             accept;
    logic             commit;
    logic             take;

    // Keeps op_ready low until the first edge after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ready_en <= 1'b0;
        else        ready_en <= 1'b1;
    end

    assign op_ready = ready_en && (state == ST_IDLE);
    assign busy     = (state != ST_IDLE);
    assign accept   = op_valid && op_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        commit    = 1'b0;
        case (state)
            ST_IDLE:   if (accept) state_nxt = ST_SETTLE;
            ST_SETTLE: state_nxt = ST_COMMIT;
            ST_COMMIT: begin
                if (!stall) begin
                    commit    = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            default:   state_nxt = ST_IDLE;
        endcase
    end

    pc_branch_decide u_decide (
        .op   (op_q),
        .z    (z),
        .take (take)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q     <= OP_NOP;
            target_q <= '0;
        end else if (accept) begin
            op_q     <= op_e'(op);
            target_q <= target;
        end
    end

    // z only reaches state through take on the commit edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc    <= '0;
            taken <= 1'b0;
        end else begin
            taken <= commit && take;
            if (commit) pc <= take ? target_q : pc + WIDTH'(1);
        end
    end

`ifdef PC_BRANCH_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            taken_cnt <= '0;
        else if (taken && (taken_cnt != {TAKEN_CNT_W{1'b1}}))
            taken_cnt <= taken_cnt + 1'b1;
    end
`endif

endmodule
